seg_scan_ctrl: RTL



---
 rtl/seg_scan_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// seven-segment display. It walks one slot per digit. Each slot opens with
// a blanking gap (all anodes off) and then drives the selected anode low
// while the matching BCD nibble sits on the shared decoder input. Display
// data is double-buffered: loads land in a stage register and move to the
// shadow register only at the frame boundary, so a frame never tears.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en         scan enable; low forces a dark display and parks the scan
//   digits_i   NUM_DIGITS BCD nibbles, digit k at [4k+3:4k], digit 0 rightmost
//   load_i     one-cycle strobe capturing digits_i
//   mask_i     per-digit enable; 0 keeps that anode dark during its slot
//   dig_data   nibble to the segment decoder (4'hF decodes to blank)
//   an_n       active-low anode enables, at most one low at a time
//   scan_idx   current slot index
//   frame_o    one-cycle pulse in the first cycle of slot 0

// Per-digit anode driver: low only when this lane owns the slot, the slot
// is past its blanking gap and the digit is not masked off.
module seg_scan_lane #(
  parameter int IDX_W = 3,
  parameter int LANE  = 0
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic             show_i,
  input  logic             mask_i,
  output logic             an_n_o
);
  assign an_n_o = ~(show_i & mask_i & (idx_i == IDX_W'(LANE)));
endmodule

module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 5000,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic                    load_i,
  input  logic [NUM_DIGITS-1:0]   mask_i,
  output logic [3:0]              dig_data,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [IDX_W-1:0]        scan_idx,
  output logic                    frame_o
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  // Scan position and data buffers.
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            run_q, run_d;
  logic [NUM_DIGITS-1:0][3:0]      stage_q, stage_d;
  logic [NUM_DIGITS-1:0][3:0]      shadow_q, shadow_d;
  logic                            pend_q, pend_d;

  // Registered outputs.
  logic [NUM_DIGITS-1:0]           an_n_q, an_n_d;
  logic [3:0]                      dig_q, dig_d;
  logic [IDX_W-1:0]                scan_q;
  logic                            frame_q, frame_d;

  logic [NUM_DIGITS-1:0][3:0]      digits_w;
  logic                            slot_end, idx_last, commit, show_d;

  assign digits_w = digits_i;

  // run_q marks that the scan has already produced its first cycle since
  // reset or the last enable rise; until then the next enabled cycle is the
  // start of a fresh frame rather than an increment.
  assign slot_end = run_q && (cnt_q == CNT_W'(SLOT_CYCLES - 1));
  assign idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign commit   = en && slot_end && idx_last;

  // Scan position next state.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    run_d = en;
    if (!en || !run_q) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Double-buffer next state. A load on the commit edge, or while the scan
  // is disabled, goes straight to the shadow so it is not held back a frame.
  always_comb begin
    stage_d  = stage_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (!en) begin
      if (load_i) begin
        shadow_d = digits_w;
        pend_d   = 1'b0;
      end
    end else if (commit) begin
      if (load_i) begin
        shadow_d = digits_w;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        shadow_d = stage_q;
        pend_d   = 1'b0;
      end
    end else if (load_i) begin
      stage_d = digits_w;
      pend_d  = 1'b1;
    end
  end

  // Outputs are computed from the next-state position so the registered
  // outputs line up with the (cnt, idx) held in the same cycle.
  assign show_d  = en && (cnt_d >= CNT_W'(BLANK_CYCLES));
  assign frame_d = en && (!run_q || commit || (slot_end && idx_last));
  assign dig_d   = en ? shadow_d[idx_d] : 4'hF;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
    seg_scan_lane #(
      .IDX_W (IDX_W),
      .LANE  (k)
    ) u_lane (
      .idx_i  (idx_d),
      .show_i (show_d),
      .mask_i (mask_i[k]),
      .an_n_o (an_n_d[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      run_q    <= 1'b0;
      stage_q  <= {NUM_DIGITS{4'hF}};
      shadow_q <= {NUM_DIGITS{4'hF}};
      pend_q   <= 1'b0;
      an_n_q   <= '1;
      dig_q    <= 4'hF;
      scan_q   <= '0;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      run_q    <= run_d;
      stage_q  <= stage_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      an_n_q   <= an_n_d;
      dig_q    <= dig_d;
      scan_q   <= idx_d;
      frame_q  <= frame_d;
    end
  end

  assign an_n     = an_n_q;
  assign dig_data = dig_q;
  assign scan_idx = scan_q;
  assign frame_o  = frame_q;

endmodule
